// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads over a valid/ready request channel
// and latches the returned instruction. Optional misaligned-PC trap: FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_update,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_cur,
  output logic [31:0] pc_old,
  output logic        busy,
  output logic        fetch_fault,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        misaligned,
  output logic [31:0] bad_addr,
`endif
  output logic        proto_err
);

  localparam logic PcSrcIncrement = 1'b0;
  localparam logic PcSrcJump      = 1'b1;

  localparam logic [31:0] NopInstr    = 32'h0000_0013;
  localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_old_q, pc_old_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic        proto_q, proto_d;
  logic        busy_w;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
  logic [31:0] bad_q, bad_d;
`endif

  assign busy_w = (state_q == StReq) || (state_q == StWait);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_old_d = pc_old_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    proto_d  = proto_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d    = mis_q;
    bad_d    = bad_q;
`endif

    // PC is frozen while a fetch is in flight so mem_addr stays stable.
    if (pc_update) begin
      if (busy_w) begin
        proto_d = 1'b1;
      end else if (pc_src == PcSrcJump) begin
        pc_d = pc_target & 32'hFFFF_FFFE;
      end else begin
        pc_d = pc_old_q + 32'd4;
      end
    end

    unique case (state_q)
      StIdle, StHold: begin
        if (fetch_start) begin
          fault_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          // Checked against the PC the request would actually use.
          if (pc_d[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            bad_d   = pc_d;
            state_d = StIdle;
          end else begin
            mis_d   = 1'b0;
            state_d = StReq;
          end
`else
          state_d = StReq;
`endif
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          state_d = StWait;
          cnt_d   = 8'd0;
        end
      end
      StWait: begin
        if (mem_rsp_valid) begin
          instr_d  = mem_rsp_data;
          pc_old_d = pc_q;
          state_d  = StHold;
        end else if (cnt_q == TimeoutLast) begin
          fault_d = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      pc_old_q <= 32'h0;
      instr_q  <= NopInstr;
      cnt_q    <= 8'd0;
      fault_q  <= 1'b0;
      proto_q  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
      bad_q    <= 32'h0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_old_q <= pc_old_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      proto_q  <= proto_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q    <= mis_d;
      bad_q    <= bad_d;
`endif
    end
  end

  assign mem_req_valid = (state_q == StReq);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign mem_addr      = pc_q;
  assign misaligned    = mis_q;
  assign bad_addr      = bad_q;
`else
  assign mem_addr      = {pc_q[31:2], 2'b00};
`endif
  assign instr         = instr_q;
  assign instr_valid   = (state_q == StHold);
  assign pc_cur        = pc_q;
  assign pc_old        = pc_old_q;
  assign busy          = busy_w;
  assign fetch_fault   = fault_q;
  assign proto_err     = proto_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table, corner-case
// sequences and randomized stimulus against a transaction-level reference model.
module tb_instruction_fetch_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_start = 1'b0;
  logic        pc_update = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_target = 32'h0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_cur;
  logic [31:0] pc_old;
  logic        busy;
  logic        fetch_fault;
  logic        proto_err;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned;
  logic [31:0] bad_addr;
`endif

  instruction_fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_start  (fetch_start),
    .pc_update    (pc_update),
    .pc_src       (pc_src),
    .pc_target    (pc_target),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc_cur       (pc_cur),
    .pc_old       (pc_old),
    .busy         (busy),
    .fetch_fault  (fetch_fault),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misaligned   (misaligned),
    .bad_addr     (bad_addr),
`endif
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a fetch is either requested-not-accepted, accepted-awaiting-data, or
  // complete; wait_n counts WAIT cycles spent without data.
  bit          m_req, m_wait, m_have, m_fault, m_proto;
  int          m_wait_n;
  logic [31:0] m_pc, m_pc_old, m_instr;

  task automatic m_reset();
    m_req = 0; m_wait = 0; m_have = 0; m_fault = 0; m_proto = 0; m_wait_n = 0;
    m_pc = 32'h0; m_pc_old = 32'h0; m_instr = 32'h0000_0013;
  endtask

  task automatic model_step(input bit fs, input bit upd, input bit src, input logic [31:0] tgt,
                            input bit rdy, input bit rsp, input logic [31:0] data);
    bit          inflight;
    logic [31:0] next_pc;
    inflight = m_req || m_wait;
    next_pc  = m_pc;
    if (upd) begin
      if (inflight) m_proto = 1;
      else next_pc = src ? {tgt[31:1], 1'b0} : m_pc_old + 32'd4;
    end
    if (!inflight) begin
      if (fs) begin m_fault = 0; m_req = 1; m_have = 0; end
    end else if (m_req) begin
      if (rdy) begin m_req = 0; m_wait = 1; m_wait_n = 0; end
    end else if (rsp) begin
      m_instr = data; m_pc_old = m_pc; m_wait = 0; m_have = 1;
    end else begin
      m_wait_n++;
      if (m_wait_n == TO) begin m_fault = 1; m_wait = 0; m_have = 0; end
    end
    m_pc = next_pc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'(m_req));
    chk({tag, ".mem_addr"}, mem_addr, {m_pc[31:2], 2'b00});
    chk({tag, ".busy"}, 32'(busy), 32'(m_req || m_wait));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(m_have));
    chk({tag, ".pc_cur"}, pc_cur, m_pc);
    chk({tag, ".pc_old"}, pc_old, m_pc_old);
    chk({tag, ".instr"}, instr, m_instr);
    chk({tag, ".fetch_fault"}, 32'(fetch_fault), 32'(m_fault));
    chk({tag, ".proto_err"}, 32'(proto_err), 32'(m_proto));
  endtask

  // Drive one cycle's inputs (starting just after an edge), advance the model, check after edge.
  task automatic step(input string tag, input bit fs, input bit upd, input bit src,
                      input logic [31:0] tgt, input bit rdy, input bit rsp,
                      input logic [31:0] data);
    fetch_start = fs; pc_update = upd; pc_src = src; pc_target = tgt;
    mem_req_ready = rdy; mem_rsp_valid = rsp; mem_rsp_data = data;
    model_step(fs, upd, src, tgt, rdy, rsp, data);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit          fs, upd, src;
    logic [31:0] tgt;
    bit          rdy, rsp;
    logic [31:0] data;
    bit          e_req, e_iv;
    logic [31:0] e_addr, e_pc, e_pc_old, e_instr;
  } vec_t;

  vec_t vecs[13];

  task automatic set_vec(input int i, input bit fs, input bit upd, input bit src,
                         input logic [31:0] tgt, input bit rdy, input bit rsp,
                         input logic [31:0] data, input bit e_req, input bit e_iv,
                         input logic [31:0] e_addr, input logic [31:0] e_pc,
                         input logic [31:0] e_pc_old, input logic [31:0] e_instr);
    vecs[i] = '{fs, upd, src, tgt, rdy, rsp, data, e_req, e_iv, e_addr, e_pc, e_pc_old, e_instr};
  endtask

  logic [31:0] held_instr;

  initial begin
    m_reset();
    //          fs upd src tgt           rdy rsp data          req iv addr          pc            pc_old        instr
    set_vec(0,  1, 0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 32'h0,         32'h0,        32'h0,        32'h0000_0013);
    set_vec(1,  0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 0, 32'h0,         32'h0,        32'h0,        32'h0000_0013);
    set_vec(2,  0, 0, 0, 32'h0,          0, 1, 32'h0100_00EF,  0, 1, 32'h0,         32'h0,        32'h0,        32'h0100_00EF);
    set_vec(3,  1, 1, 1, 32'h10,         0, 0, 32'h0,          1, 0, 32'h10,        32'h10,       32'h0,        32'h0100_00EF);
    set_vec(4,  0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 0, 32'h10,        32'h10,       32'h0,        32'h0100_00EF);
    set_vec(5,  0, 0, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,  0, 1, 32'h10,        32'h10,       32'h10,       32'hDEAD_BEEF);
    set_vec(6,  0, 1, 1, 32'hFFFF_FFFD,  0, 0, 32'h0,          0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h10,      32'hDEAD_BEEF);
    set_vec(7,  1, 0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h10,      32'hDEAD_BEEF);
    set_vec(8,  0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h10,      32'hDEAD_BEEF);
    set_vec(9,  0, 0, 0, 32'h0,          0, 1, 32'h0000_0033,  0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0033);
    set_vec(10, 0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 1, 32'h0,         32'h0,        32'hFFFF_FFFC, 32'h0000_0033);
    set_vec(11, 0, 1, 1, 32'h0000_0103,  0, 0, 32'h0,          0, 1, 32'h100,       32'h102,      32'hFFFF_FFFC, 32'h0000_0033);
    set_vec(12, 0, 0, 0, 32'h0,          1, 1, 32'h0000_0055,  0, 1, 32'h100,       32'h102,      32'hFFFF_FFFC, 32'h0000_0033);

    // Reset values
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].fs, vecs[i].upd, vecs[i].src, vecs[i].tgt,
           vecs[i].rdy, vecs[i].rsp, vecs[i].data);
      chk($sformatf("tbl%0d.mem_req_valid", i), 32'(mem_req_valid), 32'(vecs[i].e_req));
      chk($sformatf("tbl%0d.instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_iv));
      chk($sformatf("tbl%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("tbl%0d.pc_cur", i), pc_cur, vecs[i].e_pc);
      chk($sformatf("tbl%0d.pc_old", i), pc_old, vecs[i].e_pc_old);
      chk($sformatf("tbl%0d.instr", i), instr, vecs[i].e_instr);
    end

    // Back-pressure: ready low for 5 cycles keeps the request stable
    step("bp_start", 1, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step("bp_hold", 0, 0, 0, 32'h0, 0, 1, 32'h1111_1111);
      chk("bp.req_valid", 32'(mem_req_valid), 32'd1);
      chk("bp.addr", mem_addr, 32'h100);
    end
    step("bp_accept", 0, 0, 0, 32'h0, 1, 0, 32'h0);
    chk("bp.wait_entered", 32'({busy, mem_req_valid}), 32'b10);
    step("bp_rsp", 0, 0, 0, 32'h0, 0, 1, 32'hCAFE_0013);
    chk("bp.pc_old", pc_old, 32'h102);

    // Timeout after TO wait cycles; a late response is ignored
    step("to_start", 1, 0, 0, 32'h0, 0, 0, 32'h0);
    step("to_accept", 0, 0, 0, 32'h0, 1, 0, 32'h0);
    for (int i = 0; i < int'(TO) - 1; i++) step("to_wait", 0, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("to.no_fault_yet", 32'(fetch_fault), 32'd0);
    step("to_expire", 0, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("to.fault", 32'({fetch_fault, busy, instr_valid}), 32'b100);
    held_instr = instr;
    step("to_late_rsp", 0, 0, 0, 32'h0, 0, 1, 32'h7777_7777);
    chk("to.instr_kept", instr, 32'hCAFE_0013);
    step("to_refetch", 1, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("to.fault_cleared", 32'(fetch_fault), 32'd0);

    // pc_update while busy flags a protocol error and leaves the PC alone
    step("pe_accept", 0, 0, 0, 32'h0, 1, 0, 32'h0);
    step("pe_update", 0, 1, 1, 32'h40, 0, 0, 32'h0);
    chk("pe.proto_err", 32'(proto_err), 32'd1);
    chk("pe.pc_cur", pc_cur, 32'h102);

    // Asynchronous reset in WAIT, then a stale response
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    check_all("async_reset");
    chk("ar.instr", instr, 32'h0000_0013);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("ar_stale_rsp", 0, 0, 0, 32'h0, 0, 1, 32'h9999_9999);
    chk("ar.instr_valid", 32'(instr_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 12), 1'($urandom),
           $urandom, ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 35), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream of decode in the multi-cycle core. Owns the architectural PC and issues instruction reads to unified memory over a valid/ready request plus response-valid handshake.
- Latches the returned word and the PC it came from (pc_old), and holds both stable for decode and execute.
- Applies PC updates (increment or jump) commanded by the control FSM in UNCONDJUMP, BRANCH and similar states.
- Driven by the control FSM's FETCH and FETCH_WAIT states.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- TIMEOUT_CYCLES, 16: cycles allowed in WAIT before fault; legal range 1..255.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_start  in  1  FSM pulse in FETCH: begin fetch at pc_cur
- pc_update  in  1  commit a PC update this cycle
- pc_src  in  1  pc_src_t: PC_SRC__INCREMENT (pc_old+4) or PC_SRC__JUMP (pc_target)
- pc_target  in  32  jump/branch target from ALU
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  request address (= pc_cur while mem_req_valid)
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  32  read data
- instr  out  32  latched instruction
- instr_valid  out  1  high while instr/pc_old hold a fetched word
- pc_cur  out  32  architectural PC (next fetch address)
- pc_old  out  32  address of instr
- busy  out  1  state is REQ or WAIT
- fetch_fault  out  1  sticky timeout flag; cleared by next accepted fetch_start
- proto_err  out  1  sticky: pc_update seen while busy; cleared only by reset

Behaviour:
- Reset values: pc_cur=RESET_PC, pc_old=0, instr=32'h0000_0013 (NOP), instr_valid=0, mem_req_valid=0, mem_addr=RESET_PC, all flags 0, state IDLE, timeout counter 0.
- Reset asserted mid-operation aborts any request immediately. Late mem_rsp_valid after reset is ignored.
- States:
  - IDLE: no fetched word yet, or a fault occurred.
  - REQ: mem_req_valid=1.
  - WAIT: request accepted, awaiting data.
  - HOLD: instr valid.
- IDLE/HOLD -> REQ on fetch_start. instr_valid drops to 0 on that edge. fetch_fault clears.
- REQ -> WAIT on the edge where mem_req_ready=1. mem_req_valid stays high until then; mem_addr is stable while valid.
- WAIT, mem_rsp_valid=1: instr<=mem_rsp_data, pc_old<=pc_cur, then -> HOLD. instr_valid=1 from the next cycle.
- Minimum latency from fetch_start to instr_valid, with ready=1 in REQ and rsp the cycle after acceptance: 3 edges.
- Timeout: counter increments each WAIT cycle and resets on entering WAIT. If it reaches TIMEOUT_CYCLES without rsp: fetch_fault<=1, -> IDLE, instr unchanged, instr_valid=0.
- mem_rsp_valid outside WAIT: ignored.
- fetch_start while busy: ignored.
- pc_update in IDLE/HOLD: takes effect next edge.
  - INCREMENT: pc_cur<=pc_old+4.
  - JUMP: pc_cur<=pc_target with bit 0 cleared.
  - Arithmetic is 32-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0.
  - instr/pc_old/instr_valid are unaffected.
- pc_update while busy: ignored, proto_err<=1.
- pc_update and fetch_start in the same cycle in HOLD: both accepted. The request issues at the updated pc_cur, since REQ begins next cycle.
- pc_cur changes only via reset or pc_update.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit) and output bad_addr (32 bits).
  - fetch_start with pc_cur[1:0]!=0 does not issue a request. It sets misaligned=1 and bad_addr=pc_cur, and the state goes to IDLE.
  - misaligned clears on the next accepted fetch_start with an aligned PC.
- Undefined:
  - No extra ports.
  - mem_addr is driven as {pc_cur[31:2],2'b00}. pc_cur itself is unchanged.

Test Plan:
- Reset, memory word 0=32'h010000EF, fetch_start, ready=1, rsp next cycle -> instr=32'h010000EF, pc_old=0, instr_valid=1 three edges after fetch_start.
- In HOLD, pc_update JUMP with pc_target=16, then fetch_start -> mem_addr=16 during REQ, pc_old=16 after rsp.
- pc_update INCREMENT with pc_old=32'hFFFF_FFFC -> pc_cur=0. pc_update JUMP with pc_target=32'h0000_0103 -> pc_cur=32'h0000_0102.
- mem_req_ready held low 5 cycles -> mem_req_valid and mem_addr stable for all 5 cycles, WAIT entered on the edge where ready rises.
- TIMEOUT_CYCLES=4, no rsp -> fetch_fault=1 after 4 WAIT cycles, state IDLE. Then rsp_valid pulse -> instr unchanged.
- pc_update pulsed in WAIT -> proto_err=1, pc_cur unchanged. Assert reset mid-WAIT -> all outputs at reset values.
